// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX-stage controller and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             whi;
    logic             wlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, whi, wlo, wdata,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, a, b, whi, wlo, wdata,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO; one bit per clock on magnitudes,
// with sign correction applied in a final fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic               busy_q, done_q, divzero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [1:0]         op_q;
    logic               sa_q, sb_q, bzero_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH:0]   acc_q, acc_step;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH:0]   shl;
    logic [2*WIDTH-1:0] prod;
    logic               is_signed;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic use_sign);
        return (use_sign && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign is_signed = ~op_q[0];
    assign prod      = cond_neg2(acc_q[2*WIDTH-1:0], is_signed & (sa_q ^ sb_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (count_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
        shl   = {acc_q[2*WIDTH-1:0], 1'b0};
        trial = shl[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        if (op_q[1])
            acc_step = trial[WIDTH] ? shl : {trial, shl[WIDTH-1:1], 1'b1};
        else if (acc_q[0])
            acc_step = {1'b0, sum, acc_q[WIDTH-1:1]};
        else
            acc_step = {1'b0, acc_q[2*WIDTH:1]};
    end

    // Control and architectural state (HI/LO are reset alongside the flags).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.whi) hi_q <= bus.wdata;
                    if (bus.wlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        busy_q    <= 1'b1;
                        divzero_q <= 1'b0;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (op_q[1]) begin
                        // Remainder negation also restores a negative dividend when b=0.
                        hi_q      <= cond_neg(acc_q[2*WIDTH-1:WIDTH], is_signed & sa_q);
                        lo_q      <= bzero_q ? '1
                                             : cond_neg(acc_q[WIDTH-1:0], is_signed & (sa_q ^ sb_q));
                        divzero_q <= bzero_q;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on issue.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.start) begin
            op_q    <= bus.op;
            sa_q    <= bus.a[WIDTH-1];
            sb_q    <= bus.b[WIDTH-1];
            bzero_q <= (bus.b == '0);
            opnd_q  <= magnitude(bus.b, ~bus.op[0]);
            acc_q   <= {{(WIDTH+1){1'b0}}, magnitude(bus.a, ~bus.op[0])};
            count_q <= CW'(WIDTH-1);
        end else if (state_q == RUN) begin
            acc_q   <= acc_step;
            count_q <= count_q - 1'b1;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] p;
        longint      q, r;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (op)
            2'b00: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                    ed = 1'b1;
                end else if (op == 2'b10) begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, bus.busy}, 64'd0);
    endtask

    // Issue one op, check latency, result, flags and the single-cycle done pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          n;
        model(op, a, b, eh, el, ed);
        wait_idle({tag, "_idle"});
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
        chk({tag, "_dzclr"}, {63'd0, bus.divzero}, 64'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(W + 1));
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
        chk({tag, "_dz"}, {63'd0, bus.divzero}, {63'd0, ed});
        chk({tag, "_nbusy"}, {63'd0, bus.busy}, 64'd0);
        tick();
        chk({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_hold"}, {bus.hi, bus.lo}, {eh, el});
    endtask

    initial begin
        logic [31:0] ta [0:39];
        logic [31:0] tb [0:39];
        logic [1:0]  top [0:39];
        logic [31:0] eh, el, hi0, rh1, rl1, rh2, rl2;
        logic        ed;
        int          dones, n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.whi   = 1'b0;
        bus.wlo   = 1'b0;
        bus.wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dz", {63'd0, bus.divzero}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        // mthi / mtlo while idle, then hold with no write
        bus.whi = 1'b1; bus.wdata = 32'hA5A5_1234;
        tick();
        bus.whi = 1'b0; bus.wlo = 1'b1; bus.wdata = 32'h0BAD_CAFE;
        tick();
        bus.wlo = 1'b0; bus.wdata = 32'h1111_1111;
        repeat (3) tick();
        chk("mthi_mtlo", {bus.hi, bus.lo}, 64'hA5A5_1234_0BAD_CAFE);

        run_op("t1_mult", 2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("t1_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("t2_multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("t3_div", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("t3_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("t3_divu", 2'b11, 32'd100, 32'd7);
        chk("t3u_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run_op("t4_divu0", 2'b11, 32'd7, 32'd0);
        chk("t4_const", {bus.hi, bus.lo}, {32'd7, 32'hFFFF_FFFF});
        run_op("t4_mult", 2'b00, 32'd3, 32'd4);
        run_op("div0_neg", 2'b10, 32'h8000_0003, 32'd0);
        run_op("div0_min", 2'b10, 32'h8000_0000, 32'd0);
        run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("wrap_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

        // write on the accepted start edge happens, then the result overwrites it
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
        bus.whi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b0; bus.whi = 1'b0;
        chk("wr_at_start", {32'd0, bus.hi}, 64'h0000_0000_DEAD_BEEF);
        n = 0;
        while (!bus.done && n < 40) begin tick(); n++; end
        chk("wr_overwrite", {bus.hi, bus.lo}, {32'd0, 32'd81});

        // start held high with fresh operands every cycle
        wait_idle("t5_idle");
        for (int k = 0; k < 40; k++) begin
            top[k] = 2'($urandom_range(0, 3));
            ta[k]  = $urandom;
            tb[k]  = (k == 34) ? 32'd0 : $urandom;
        end
        hi0   = bus.hi;
        dones = 0;
        rh1 = '0; rl1 = '0;
        for (int k = 0; k < 40; k++) begin
            bus.start = 1'b1;
            bus.op    = top[k];
            bus.a     = ta[k];
            bus.b     = tb[k];
            bus.whi   = (k >= 1 && k <= 32) ? k[0] : 1'b0;
            bus.wdata = $urandom;
            tick();
            if (k >= 1 && k <= 32) chk("t5_hi_busy", {32'd0, bus.hi}, {32'd0, hi0});
            if (bus.done && k <= 33) begin
                dones++;
                rh1 = bus.hi;
                rl1 = bus.lo;
            end
        end
        bus.start = 1'b0;
        bus.whi   = 1'b0;
        chk("t5_dones", 64'(dones), 64'd1);
        model(top[0], ta[0], tb[0], eh, el, ed);
        chk("t5_first", {rh1, rl1}, {eh, el});
        n = 0;
        while (!bus.done && n < 60) begin tick(); n++; end
        rh2 = bus.hi; rl2 = bus.lo;
        model(top[34], ta[34], tb[34], eh, el, ed);
        chk("t5_second", {rh2, rl2}, {eh, el});
        chk("t5_second_dz", {63'd0, bus.divzero}, {63'd0, ed});

        // reset in the middle of RUN
        wait_idle("t6_idle");
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1234; bus.b = 32'd5678;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", {63'd0, bus.busy}, 64'd0);
        chk("t6_hilo", {bus.hi, bus.lo}, 64'd0);
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done) dones++;
            tick();
        end
        chk("t6_nodone", 64'(dones), 64'd0);
        run_op("t6_mult", 2'b00, 32'd6, 32'd7);
        chk("t6_const", {bus.hi, bus.lo}, {32'd0, 32'd42});

        // randomized ops with occasional zero / extreme operands
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
